// File: rtl/dot_pkg.sv
// Shared types for the dot-product operand issuer.
package dot_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } issuer_state_e;

    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/dot_issue_skid.sv
// Two-entry valid/ready FIFO holding returned operand beats.
module dot_issue_skid
    import dot_pkg::*;
#(
    parameter type T = logic [7:0]
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_valid,
    input  T           i_data,
    output logic       o_valid,
    input  logic       i_ready,
    output T           o_data,
    output logic [1:0] o_count
);

    T           r_mem [SKID_DEPTH];
    logic       r_wr;
    logic       r_rd;
    logic [1:0] r_cnt;
    logic       w_push;
    logic       w_pop;

    assign w_push  = i_valid && (r_cnt != 2'(SKID_DEPTH));
    assign w_pop   = o_valid && i_ready;
    assign o_valid = (r_cnt != 2'd0);
    assign o_data  = r_mem[r_rd];
    assign o_count = r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr  <= 1'b0;
            r_rd  <= 1'b0;
            r_cnt <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= ~r_wr;
            end
            if (w_pop) begin
                r_rd <= ~r_rd;
            end
            r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
        end
    end

endmodule

// File: rtl/dot_operand_issuer.sv
// Streams A/B lane vectors from the operand buffer to the FMA lanes.
// DOT_ISSUE_ZERO_SKIP_EN: also clear mask bits of lanes holding +/-0.
module dot_operand_issuer
    import dot_pkg::*;
#(
    parameter int LANES  = 1,
    parameter int ELEM_W = 32,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 16,
    parameter int TAG_W  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_W-1:0]       req_a_base,
    input  logic [ADDR_W-1:0]       req_b_base,
    input  logic [LEN_W-1:0]        req_len,
    input  logic [TAG_W-1:0]        req_tag,
    output logic                    buf_rd_en,
    output logic [ADDR_W-1:0]       buf_rd_a_addr,
    output logic [ADDR_W-1:0]       buf_rd_b_addr,
    input  logic [LANES*ELEM_W-1:0] buf_rd_a_data,
    input  logic [LANES*ELEM_W-1:0] buf_rd_b_data,
    output logic                    op_valid,
    input  logic                    op_ready,
    output logic [LANES*ELEM_W-1:0] op_a,
    output logic [LANES*ELEM_W-1:0] op_b,
    output logic [LANES-1:0]        op_mask,
    output logic                    op_last,
    output logic [TAG_W-1:0]        op_tag,
    output logic                    busy
);

    localparam int VW = LANES * ELEM_W;
    localparam logic [LEN_W:0] W_LANES = (LEN_W+1)'(LANES);

    typedef logic [VW-1:0] lane_vec_t;

    typedef struct packed {
        lane_vec_t          a;
        lane_vec_t          b;
        logic [LANES-1:0]   mask;
        logic               last;
        logic [TAG_W-1:0]   tag;
    } dot_beat_t;

    issuer_state_e    r_state;
    issuer_state_e    w_next;
    logic [ADDR_W-1:0] r_a_base;
    logic [ADDR_W-1:0] r_b_base;
    logic [LEN_W-1:0] r_beat_cnt;
    logic [LEN_W-1:0] r_last_beat;
    logic [LANES-1:0] r_tail_mask;
    logic [TAG_W-1:0] r_tag;
    logic             r_inflight;
    logic [LANES-1:0] r_rd_mask;
    logic             r_rd_last;

    logic [1:0]       w_occ;
    logic             w_accept;
    logic             w_pop;
    logic             w_space;
    logic             w_rd_last;
    logic [LEN_W:0]   w_beats;
    logic [LEN_W:0]   w_tail_cnt;
    logic [LANES-1:0] w_tail_mask;
    dot_beat_t        w_ret;
    dot_beat_t        w_head;

    assign w_accept  = req_valid && req_ready;
    assign w_pop     = op_valid && op_ready;
    assign w_rd_last = (r_beat_cnt == r_last_beat);

    // Count the beat leaving this cycle so the pipe refills at full rate.
    assign w_space = ({1'b0, w_occ} + {2'b0, r_inflight})
                     < (3'd2 + {2'b0, w_pop});

    assign buf_rd_a_addr = r_a_base + ADDR_W'(r_beat_cnt);
    assign buf_rd_b_addr = r_b_base + ADDR_W'(r_beat_cnt);

    always_comb begin
        w_beats = ((LEN_W+1)'(req_len) + W_LANES - (LEN_W+1)'(1)) / W_LANES;
        if (req_len == '0) begin
            w_beats = (LEN_W+1)'(1);
        end
        w_tail_cnt = (LEN_W+1)'(req_len)
                   - (w_beats - (LEN_W+1)'(1)) * W_LANES;
        for (int i = 0; i < LANES; i++) begin
            w_tail_mask[i] = ((LEN_W+1)'(i) < w_tail_cnt);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_next = ISSUE;
            ISSUE:   if (buf_rd_en && w_rd_last) w_next = DRAIN;
            DRAIN:   if (w_occ == 2'd0 && !r_inflight) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        buf_rd_en = 1'b0;
        unique case (r_state)
            IDLE:    req_ready = reset;
            ISSUE:   buf_rd_en = w_space;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a_base    <= '0;
            r_b_base    <= '0;
            r_beat_cnt  <= '0;
            r_last_beat <= '0;
            r_tail_mask <= '0;
            r_tag       <= '0;
            r_inflight  <= 1'b0;
            r_rd_mask   <= '0;
            r_rd_last   <= 1'b0;
        end else begin
            r_inflight <= buf_rd_en;
            if (w_accept) begin
                r_a_base    <= req_a_base;
                r_b_base    <= req_b_base;
                r_tag       <= req_tag;
                r_beat_cnt  <= '0;
                r_last_beat <= LEN_W'(w_beats - (LEN_W+1)'(1));
                r_tail_mask <= w_tail_mask;
            end
            if (buf_rd_en) begin
                r_rd_mask  <= w_rd_last ? r_tail_mask : '1;
                r_rd_last  <= w_rd_last;
                r_beat_cnt <= r_beat_cnt + LEN_W'(1);
            end
        end
    end

    always_comb begin
        w_ret      = '0;
        w_ret.last = r_rd_last;
        w_ret.tag  = r_tag;
        for (int i = 0; i < LANES; i++) begin
            if (r_rd_mask[i]) begin
                w_ret.a[i*ELEM_W +: ELEM_W] = buf_rd_a_data[i*ELEM_W +: ELEM_W];
                w_ret.b[i*ELEM_W +: ELEM_W] = buf_rd_b_data[i*ELEM_W +: ELEM_W];
            end
`ifdef DOT_ISSUE_ZERO_SKIP_EN
            w_ret.mask[i] = r_rd_mask[i]
                && (buf_rd_a_data[i*ELEM_W +: ELEM_W-1] != '0)
                && (buf_rd_b_data[i*ELEM_W +: ELEM_W-1] != '0);
`else
            w_ret.mask[i] = r_rd_mask[i];
`endif
        end
    end

    dot_issue_skid #(
        .T(dot_beat_t)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_valid (r_inflight),
        .i_data  (w_ret),
        .o_valid (op_valid),
        .i_ready (op_ready),
        .o_data  (w_head),
        .o_count (w_occ)
    );

    assign op_a    = w_head.a;
    assign op_b    = w_head.b;
    assign op_mask = w_head.mask;
    assign op_last = w_head.last;
    assign op_tag  = w_head.tag;
    assign busy    = (r_state != IDLE) || (w_occ != 2'd0);

endmodule
